// File: rtl/cache_mem_pkg.sv
// Shared widths, address field positions, line type and FSM encoding for the
// direct-mapped write-back cache and its backing memory.
package cache_mem_pkg;
    localparam int WORD_SIZE   = 32;
    localparam int BLOCK_SIZE  = 4;
    localparam int NUM_LINES   = 4;
    localparam int MEM_BLOCKS  = 4096;
    localparam int MEM_LATENCY = 3;

    localparam int OFF_W   = $clog2(BLOCK_SIZE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = WORD_SIZE - OFF_W - IDX_W;
    localparam int MEM_AW  = $clog2(MEM_BLOCKS);
    localparam int IDX_LSB = OFF_W;
    localparam int TAG_LSB = OFF_W + IDX_W;
    localparam int MEM_LSB = OFF_W;
    localparam int CNT_W   = 2;

    typedef logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    typedef struct packed {
        logic                 wr;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } req_t;
endpackage

// File: rtl/cache_mem_if.sv
// CPU-side request and debug/status signals of the cache. The bidirectional
// data bus stays a plain inout port on the cache itself.
interface cache_mem_if;
    import cache_mem_pkg::*;
    logic                 read_CPU;
    logic                 write_CPU;
    logic [WORD_SIZE-1:0] Addr_CPU;
    logic                 Stall_PC;
    logic                 hit;
    logic [2:0]           state;
    logic                 state_cycle;

    modport master (output read_CPU, write_CPU, Addr_CPU,
                    input  Stall_PC, hit, state, state_cycle);
    modport slave  (input  read_CPU, write_CPU, Addr_CPU,
                    output Stall_PC, hit, state, state_cycle);
endinterface

// File: rtl/cache_mem_main_memory.sv
// Line-wide backing store with a fixed MEM_LATENCY-cycle transfer; done pulses
// in the last cycle of each transfer and the counter restarts on every entry.
module main_memory
    import cache_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic              we,
    input  logic [MEM_AW-1:0] blk,
    input  line_t             wdata,
    output line_t             rdata,
    output logic              done
);
    // Contents are not reset; power-up state is relied on being zero.
    line_t            mem [MEM_BLOCKS];
    logic [CNT_W-1:0] cnt;

    assign done = busy && (cnt == CNT_W'(MEM_LATENCY - 1));

    always_ff @(posedge clk) begin
        if (reset || !busy || done) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

    // Registered read; blk is stable for the whole transfer, so rdata is
    // settled well before done.
    always_ff @(posedge clk) begin
        if (done && we && !reset) mem[blk] <= wdata;
        rdata <= mem[blk];
    end
endmodule

// File: rtl/cache_mem.sv
// Direct-mapped write-back, write-allocate cache: tag/valid/dirty/data arrays
// and the access FSM; the backing store lives in main_memory.
module cache_mem
    import cache_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    inout  wire  [WORD_SIZE-1:0] Data_CPU,
    cache_mem_if.slave           bus
);
    state_t                 state_q, state_d;
    req_t                   req_q;
    logic [NUM_LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]       tag_q [NUM_LINES];
    line_t                  data_q [NUM_LINES];
    logic [WORD_SIZE-1:0]   rd_data_q;
    logic                   rd_valid_q;

    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [TAG_W-1:0]  tag;
    logic              req_in, tag_hit, mem_busy, mem_we, mem_done;
    logic [MEM_AW-1:0] mem_blk;
    line_t             mem_rdata;

    assign idx     = req_q.addr[TAG_LSB-1:IDX_LSB];
    assign off     = req_q.addr[OFF_W-1:0];
    assign tag     = req_q.addr[WORD_SIZE-1:TAG_LSB];
    assign req_in  = bus.read_CPU || bus.write_CPU;
    assign tag_hit = valid_q[idx] && (tag_q[idx] == tag);

    // Victim goes back to the block it came from; fills use the request address.
    assign mem_blk = (state_q == WRITEBACK) ? {tag_q[idx][MEM_AW-IDX_W-1:0], idx}
                                            : req_q.addr[MEM_AW+MEM_LSB-1:MEM_LSB];

    main_memory u_mem (
        .clk   (clk),
        .reset (reset),
        .busy  (mem_busy),
        .we    (mem_we),
        .blk   (mem_blk),
        .wdata (data_q[idx]),
        .rdata (mem_rdata),
        .done  (mem_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_in) state_d = COMPARE;
            COMPARE:   if (tag_hit)           state_d = RESPOND;
                       else if (dirty_q[idx]) state_d = WRITEBACK;
                       else                   state_d = ALLOCATE;
            WRITEBACK: if (mem_done) state_d = ALLOCATE;
            ALLOCATE:  if (mem_done) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.Stall_PC = (state_q != IDLE);
        bus.hit      = (state_q == COMPARE) && tag_hit;
        mem_busy     = (state_q == WRITEBACK) || (state_q == ALLOCATE);
        mem_we       = (state_q == WRITEBACK);
    end

    assign bus.state       = state_q;
    assign bus.state_cycle = mem_done;
    assign Data_CPU        = (rd_valid_q && !bus.write_CPU) ? rd_data_q : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_in) begin
                    req_q.wr   <= bus.write_CPU;
                    req_q.addr <= bus.Addr_CPU;
                    if (bus.write_CPU) req_q.data <= Data_CPU;
                    rd_valid_q <= 1'b0;
                end
                WRITEBACK: if (mem_done) dirty_q[idx] <= 1'b0;
                ALLOCATE: if (mem_done) begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                    tag_q[idx]   <= tag;
                    data_q[idx]  <= mem_rdata;
                end
                RESPOND: if (req_q.wr) begin
                    data_q[idx][off] <= req_q.data;
                    dirty_q[idx]     <= 1'b1;
                end else begin
                    rd_data_q  <= data_q[idx][off];
                    rd_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem.sv
// Scoreboard bench for cache_mem: expected read data and access latency are
// queued at issue and popped when the stall drops.
module tb_cache_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_wdata = '0;
    wire  [31:0] data_bus;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sb_data[$];
    int          sb_lat[$];

    cache_mem_if bus();

    assign data_bus = tb_drv ? tb_wdata : 'z;

    cache_mem dut (
        .clk      (clk),
        .reset    (reset),
        .Data_CPU (data_bus),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One CPU access; lat counts cycles from request to the first idle cycle.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd_exp, input int lat, input logic hit_exp,
                          input int pulses, input logic inject);
        int n;
        int np;
        @(negedge clk);
        bus.read_CPU  = !wr;
        bus.write_CPU = wr;
        bus.Addr_CPU  = addr;
        tb_drv        = wr;
        tb_wdata      = wd;
        if (!wr) sb_data.push_back(rd_exp);
        sb_lat.push_back(lat);
        @(negedge clk);
        bus.read_CPU  = 1'b0;
        bus.write_CPU = 1'b0;
        tb_drv        = 1'b0;
        chk("state_compare", 32'(bus.state), 32'd1);
        chk("hit", 32'(bus.hit), 32'(hit_exp));
        if (inject) begin
            bus.write_CPU = 1'b1;
            bus.Addr_CPU  = 32'h5;
            tb_drv        = 1'b1;
            tb_wdata      = 32'hdead;
        end
        n  = 1;
        np = 0;
        while (bus.Stall_PC && n < 40) begin
            np += int'(bus.state_cycle);
            @(negedge clk);
            n++;
            bus.write_CPU = 1'b0;
            tb_drv        = 1'b0;
        end
        chk("latency", 32'(n), 32'(sb_lat.pop_front()));
        chk("state_cycle_pulses", 32'(np), 32'(pulses));
        if (!wr) chk("rdata", data_bus, sb_data.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.read_CPU  = 1'b0;
        bus.write_CPU = 1'b0;
        bus.Addr_CPU  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_stall", 32'(bus.Stall_PC), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_state_cycle", 32'(bus.state_cycle), 32'd0);
        chk("rst_valid", 32'(dut.valid_q), 32'd0);

        //     wr    addr           wdata          rd_exp         lat hit pulses inj
        access(1'b1, 32'h0000_0005, 32'h0000_0055, 32'h0,         6, 1'b0, 1, 1'b0);
        chk("line1_dirty", 32'(dut.dirty_q[1]), 32'd1);
        access(1'b0, 32'h0000_0001, 32'h0,         32'h0000_0000, 6, 1'b0, 1, 1'b0);
        access(1'b0, 32'h0000_0005, 32'h0,         32'h0000_0055, 3, 1'b1, 0, 1'b0);
        access(1'b1, 32'h0000_0ff0, 32'h0000_0077, 32'h0,         6, 1'b0, 1, 1'b0);
        access(1'b0, 32'h0000_0ff0, 32'h0,         32'h0000_0077, 3, 1'b1, 0, 1'b0);
        access(1'b1, 32'h0000_0ff0, 32'h0000_0088, 32'h0,         3, 1'b1, 0, 1'b0);
        access(1'b0, 32'h0000_0ff0, 32'h0,         32'h0000_0088, 3, 1'b1, 0, 1'b0);
        access(1'b0, 32'h0000_1ff0, 32'h0,         32'h0000_0000, 9, 1'b0, 2, 1'b0);
        access(1'b0, 32'h0000_0ff0, 32'h0,         32'h0000_0088, 6, 1'b0, 1, 1'b0);
        // 0x4ff0 aliases memory block 0x3fc with 0xff0
        access(1'b0, 32'h0000_4ff0, 32'h0,         32'h0000_0088, 6, 1'b0, 1, 1'b0);
        // write injected while stalled must be dropped
        access(1'b0, 32'h0000_0005, 32'h0,         32'h0000_0055, 3, 1'b1, 0, 1'b1);
        access(1'b0, 32'h0000_0005, 32'h0,         32'h0000_0055, 3, 1'b1, 0, 1'b0);

        // reset in the middle of a fill
        @(negedge clk);
        bus.read_CPU = 1'b1;
        bus.Addr_CPU = 32'h0000_2000;
        @(negedge clk);
        bus.read_CPU = 1'b0;
        @(negedge clk);
        chk("state_allocate", 32'(bus.state), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_stall", 32'(bus.Stall_PC), 32'd0);
        chk("midrst_state_cycle", 32'(bus.state_cycle), 32'd0);
        chk("midrst_valid", 32'(dut.valid_q), 32'd0);
        // dirty 0x55 was never written back, so memory still holds zero
        access(1'b0, 32'h0000_0005, 32'h0,         32'h0000_0000, 6, 1'b0, 1, 1'b0);
        access(1'b0, 32'h0000_0005, 32'h0,         32'h0000_0000, 3, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cache_mem.md
# cache_mem

Direct-mapped, write-back, write-allocate data cache with its backing main memory, sitting between the CPU load/store port and the rest of the system. The CPU issues one word read or write at a time; the block stalls the PC until the access completes. It exposes its hit and FSM status for debug.

## Interface
- WORD_SIZE, 32: data and address width.
- BLOCK_SIZE, 4: words per cache line (line = 128 bits).
- NUM_LINES, 4: cache lines.
- MEM_BLOCKS, 4096: main-memory depth in lines.
- MEM_LATENCY, 3: cycles per line transfer to/from memory.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- read_CPU  in  1  word read request.
- write_CPU  in  1  word write request.
- Data_CPU  inout  32  write data from CPU / read data to CPU.
- Addr_CPU  in  32  word address: offset [1:0], index [3:2], tag [31:4].
- Stall_PC  out  1  high while an access is in progress.
- hit  out  1  tag match in COMPARE.
- state  out  3  current FSM state.
- state_cycle  out  1  memory line transfer completes this cycle.

## Operation
- States: IDLE=0, COMPARE=1, WRITEBACK=2, ALLOCATE=3, RESPOND=4.
- IDLE: if read_CPU or write_CPU, latch Addr_CPU, op (write wins if both) and, for writes, Data_CPU; go COMPARE. Requests in any other state are ignored.
- COMPARE: hit = valid & tag match. Hit -> RESPOND. Miss with dirty victim -> WRITEBACK; clean/invalid -> ALLOCATE.
- WRITEBACK: after MEM_LATENCY cycles write victim line to memory block {victim tag, index}; clear dirty; -> ALLOCATE.
- ALLOCATE: after MEM_LATENCY cycles load line from memory block Addr[13:2]; set valid, tag, dirty=0; -> RESPOND.
- RESPOND: write: merge word at offset, set dirty. Read: register selected word into read-data register, set rd_valid. -> IDLE.
- Memory indexed by word address bits [13:2]; higher bits ignored (aliasing). Contents zero at power-up, not cleared by reset.
- Data_CPU driven by block only when rd_valid=1 and write_CPU=0, else high-Z. rd_valid cleared on acceptance of any new request.
- Stall_PC = (state != IDLE). hit = 0 outside COMPARE.

## Timing
- Reset: state=IDLE, all valid/dirty=0, rd_valid=0, Stall_PC=0, hit=0, state_cycle=0, Data_CPU high-Z; in-flight access abandoned, memory untouched.
- Edge E0 samples request; COMPARE from E1.
- Hit: E1 COMPARE, E2 RESPOND, IDLE with read data valid from E3 (3 cycles).
- Clean miss: COMPARE, 3 ALLOCATE, RESPOND -> data valid 6 cycles after request.
- Dirty miss: adds 3 WRITEBACK cycles -> 9 cycles.
- state_cycle high only in last cycle of each WRITEBACK/ALLOCATE; 2-bit counter reset on state entry.

## Structure
- Package cache_mem_pkg: widths, BLOCK_SIZE, NUM_LINES, MEM_LATENCY, state enum, address field slice constants.
- Sub-module main_memory: line-wide storage, fixed-latency read/write with done pulse (drives state_cycle). Tag/valid/dirty/data arrays and FSM in top.

## Test plan
- Reset, write 0x55 to addr 0x5 -> COMPARE miss (hit=0), ALLOCATE, RESPOND; Stall_PC high 5 cycles; line 1 dirty.
- Read addr 0x1 -> miss, data 0x00000000 on Data_CPU 6 cycles after request.
- Read addr 0x5 -> hit=1 in COMPARE, 0x55 on Data_CPU 3 cycles after request.
- Write 0x77 to 0xff0 (index 0 miss, clean), read 0xff0 -> hit, 0x77; write 0x88 to 0xff0 -> hit, 3 cycles; read -> 0x88.
- Read 0x1ff0 (same index, new tag, dirty) -> WRITEBACK then ALLOCATE, state_cycle pulses twice, data 0; then read 0xff0 -> miss returns 0x88 from memory.
- Request asserted while Stall_PC=1 -> ignored; reset mid-ALLOCATE -> IDLE next cycle, Stall_PC=0, all lines invalid.
